// File: rtl/load_store_unit.sv
// Load/store initiator: one word-aligned memory access per request, read-modify-write
// for sub-word stores, extended load data and misalignment rejection.
module load_store_unit #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_misaligned,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_en,
    output logic [XLEN-1:0]       mem_write_data,
    input  logic [XLEN-1:0]       mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RMW_READ, S_WRITE, S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                state_q, state_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       word_q, word_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  misal_q, misal_d;
    logic                  req_misal;

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                    input logic [1:0] size,
                                                    input logic [1:0] off,
                                                    input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (size)
            SZ_BYTE: load_extend = uns ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
            SZ_HALF: load_extend = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // Replace only the addressed lane of the previously read word.
    function automatic logic [XLEN-1:0] merge_lane(input logic [XLEN-1:0] word,
                                                   input logic [XLEN-1:0] wdata,
                                                   input logic half,
                                                   input logic [1:0] off);
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] ins;
        if (half) begin
            mask = XLEN'(16'hFFFF) << {off[1], 4'b0000};
            ins  = XLEN'(wdata[15:0]) << {off[1], 4'b0000};
        end else begin
            mask = XLEN'(8'hFF) << {off, 3'b000};
            ins  = XLEN'(wdata[7:0]) << {off, 3'b000};
        end
        merge_lane = (word & ~mask) | ins;
    endfunction

    always_comb begin
        req_misal = 1'b0;
        case (req_size)
            SZ_BYTE: req_misal = 1'b0;
            SZ_HALF: req_misal = req_addr[0];
            SZ_WORD: req_misal = (req_addr[1:0] != 2'b00);
            default: req_misal = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        rdata_d    = rdata_q;
        misal_d    = misal_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    if (req_misal) begin
                        state_d = S_RESP;
                        rdata_d = '0;
                        misal_d = 1'b1;
                    end else if (!req_write) begin
                        state_d = S_LOAD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW_READ;
                    end
                end
            end
            S_LOAD: begin
                word_d  = mem_read_data;
                rdata_d = load_extend(mem_read_data, size_q, addr_q[1:0], unsigned_q);
                misal_d = 1'b0;
                state_d = S_RESP;
            end
            S_RMW_READ: begin
                word_d  = mem_read_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                rdata_d = '0;
                misal_d = 1'b0;
                state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
            misal_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            rdata_q    <= rdata_d;
            misal_q    <= misal_d;
        end
    end

    // All handshake and memory strobes decode straight from the state flop.
    assign req_ready       = (state_q == S_IDLE);
    assign resp_valid      = (state_q == S_RESP);
    assign mem_write_en    = (state_q == S_WRITE);
    assign mem_addr        = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = misal_q;
    assign mem_write_data  = !mem_write_en        ? '0 :
                             (size_q == SZ_WORD)  ? wdata_q :
                             merge_lane(word_q, wdata_q, size_q[0], addr_q[1:0]);

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side initiator between the CPU execute stage and the byte-addressed data memory. Accepts one load or store per handshake and performs a single word-aligned memory access, or a read-modify-write for byte and halfword stores, since the memory port writes whole 32-bit words only. Returns zero- or sign-extended load data, and flags misaligned accesses without touching memory.

## Interface
- XLEN, 32: data width; the only supported value is 32.
- ADDR_WIDTH, 32: byte-address width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  load result; 0 for stores and errors.
- resp_misaligned  out  1  valid with resp_valid; access rejected.
- mem_addr  out  ADDR_WIDTH  word-aligned address, {req_addr[ADDR_WIDTH-1:2], 2'b00}.
- mem_write_en  out  1  memory writes mem_write_data at the rising edge.
- mem_write_data  out  XLEN  byte lane i (bits 8i+7:8i) goes to mem_addr+i.
- mem_read_data  in  XLEN  combinational read of mem_addr; same lane order as writes.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write, size, unsigned, addr, wdata.
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0, or size 11. Next state is RESP with resp_misaligned=1; no memory access.
- Aligned load goes to LOAD. Word store goes to WRITE. Byte or half store goes to RMW_READ.
- LOAD: drive mem_addr and capture mem_read_data into the word register, then go to RESP.
  - Byte = word[8*off+:8] with off=addr[1:0]; half = word[16*addr[1]+:16].
  - Extend the selected lane per req_unsigned into resp_rdata.
- RMW_READ: capture mem_read_data, then go to WRITE.
- WRITE: mem_write_en=1 for exactly one cycle.
  - Word store: mem_write_data = wdata.
  - Byte or half store: captured word with the target lane replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged.
  - Then go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. resp_rdata and resp_misaligned are registered and hold until the next RESP.
- req_ready=0 in every state except IDLE. There is no back-to-back acceptance.
- mem_write_en is decoded from the registered state, so it is glitch-free and high only in WRITE.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_addr=0, mem_write_en=0, mem_write_data=0.
- Cycle 0 is the acceptance cycle. resp_valid is asserted in:
  - cycle 1 for misaligned accesses;
  - cycle 2 for loads and word stores;
  - cycle 3 for byte and half stores.
- Throughput: one request per latency+1 cycles.
- Reset mid-operation:
  - Returns to IDLE immediately; mem_write_en drops asynchronously.
  - If reset arrives before the WRITE edge, no write occurs and no response is produced.
- Requests presented outside IDLE are ignored, and the requester must hold them. req_* fields are sampled only at acceptance.
- Address arithmetic is unsigned; the top bits pass through. mem_addr never wraps within a word.

## Test plan
- Load word at 0x10 with memory word 0xDEADBEEF -> resp_valid in cycle 2, resp_rdata=0xDEADBEEF, mem_write_en never asserted.
- Load byte at 0x13 (lane 3 = 0x80), signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- Store byte 0xAA at 0x21 over word 0x11223344 -> one write cycle with mem_write_data=0x1122AA44, resp_valid in cycle 3.
- Store half 0xBEEF at 0x22 over 0x00000000 -> 0xBEEF0000 written; a following word load returns 0xBEEF0000.
- Load half at 0x05 and store word at 0x06 -> resp_misaligned=1 in cycle 1, no mem_write_en, memory unchanged.
- Assert rst during RMW_READ of a byte store -> mem_write_en stays 0, no resp_valid, req_ready=1 after release, memory unchanged.
